// File: rtl/mips_cpu_alu.sv
// mips_cpu_alu: execute-stage ALU for the multicycle MIPS-I core.
// The result r is purely combinational and covers ALU, shift and address
// arithmetic. The architectural HI/LO registers are owned here and are
// written by MULT/MULTU/DIV/DIVU (single edge) and by MTHI/MTLO.
// Optional build macro MIPS_CPU_ALU_OVERFLOW_EN adds a combinational signed
// overflow flag for ADD/SUB; r is the same with or without it.
module mips_cpu_alu #(
  parameter logic [31:0] HILO_RESET = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sa,
  input  logic        hi_write,
  input  logic        lo_write,
  output logic [31:0] r,
  output logic        zero,
  output logic [31:0] hi,
`ifdef MIPS_CPU_ALU_OVERFLOW_EN
  output logic [31:0] lo,
  output logic        overflow
`else
  output logic [31:0] lo
`endif
);

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic [DATA_W-1:0]        add_res;
  logic [DATA_W-1:0]        sub_res;
  logic [2*DATA_W-1:0]      prod_s;
  logic [2*DATA_W-1:0]      prod_u;
  logic [DATA_W-1:0]        a_mag;
  logic [DATA_W-1:0]        b_mag;
  logic [DATA_W-1:0]        divisor_s;
  logic [DATA_W-1:0]        divisor_u;
  logic [DATA_W-1:0]        quo_mag;
  logic [DATA_W-1:0]        rem_mag;
  logic [DATA_W-1:0]        quo_s;
  logic [DATA_W-1:0]        rem_s;
  logic [DATA_W-1:0]        quo_u;
  logic [DATA_W-1:0]        rem_u;
  logic                     b_is_zero;
  logic [DATA_W-1:0]        hi_q, hi_d;
  logic [DATA_W-1:0]        lo_q, lo_d;

  assign a_s     = $signed(a);
  assign b_s     = $signed(b);
  assign add_res = a + b;
  assign sub_res = a - b;

  // Full-width products; operands are explicitly extended so the low 64 bits
  // of the product are exact for both signed and unsigned interpretations.
  assign prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Signed divide is done on magnitudes and the signs are restored afterwards.
  // This gives truncation toward zero, a remainder carrying the sign of a, and
  // makes 0x80000000 / -1 fall out as quotient 0x80000000, remainder 0.
  // A zero divisor is replaced by 1 so the dividers never see 0; the result
  // is discarded in that case anyway.
  assign b_is_zero = (b == '0);
  assign a_mag     = a[DATA_W-1] ? (~a + 1'b1) : a;
  assign b_mag     = b[DATA_W-1] ? (~b + 1'b1) : b;
  assign divisor_s = b_is_zero ? {{(DATA_W-1){1'b0}}, 1'b1} : b_mag;
  assign divisor_u = b_is_zero ? {{(DATA_W-1){1'b0}}, 1'b1} : b;
  assign quo_mag   = a_mag / divisor_s;
  assign rem_mag   = a_mag % divisor_s;
  assign quo_s     = (a[DATA_W-1] ^ b[DATA_W-1]) ? (~quo_mag + 1'b1) : quo_mag;
  assign rem_s     = a[DATA_W-1] ? (~rem_mag + 1'b1) : rem_mag;
  assign quo_u     = a / divisor_u;
  assign rem_u     = a % divisor_u;

  // Combinational result mux; mult/div/idle codes drive r to zero.
  always_comb begin
    r = '0;
    case (control)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = add_res;
      OP_SUB:  r = sub_res;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: r = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_SLL:  r = b << sa;
      OP_SRL:  r = b >> sa;
      OP_SRA:  r = $unsigned(b_s >>> sa);
      default: r = '0;
    endcase
  end

  assign zero = (r == '0);

`ifdef MIPS_CPU_ALU_OVERFLOW_EN
  // Signed overflow flag for ADD/SUB; trapping is the CPU's decision.
  always_comb begin
    overflow = 1'b0;
    case (control)
      OP_ADD:  overflow = (a[DATA_W-1] == b[DATA_W-1]) && (add_res[DATA_W-1] != a[DATA_W-1]);
      OP_SUB:  overflow = (a[DATA_W-1] != b[DATA_W-1]) && (sub_res[DATA_W-1] != a[DATA_W-1]);
      default: overflow = 1'b0;
    endcase
  end
`endif

  // HI/LO next state: mult/div result, then MTHI/MTLO override per register.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (control)
      OP_MULT:  {hi_d, lo_d} = prod_s;
      OP_MULTU: {hi_d, lo_d} = prod_u;
      OP_DIV: begin
        if (!b_is_zero) begin
          hi_d = rem_s;
          lo_d = quo_s;
        end
      end
      OP_DIVU: begin
        if (!b_is_zero) begin
          hi_d = rem_u;
          lo_d = quo_u;
        end
      end
      default: ;
    endcase
    if (hi_write) hi_d = a;
    if (lo_write) lo_d = a;
  end

  // HI/LO registers with asynchronous clear to HILO_RESET.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= HILO_RESET;
      lo_q <= HILO_RESET;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mips_cpu_alu.sv
// Directed self-checking bench for mips_cpu_alu.
module tb_mips_cpu_alu;

  logic        clk;
  logic        reset;
  logic [3:0]  control;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  sa;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] r;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MIPS_CPU_ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int errors = 0;
  int checks = 0;

  mips_cpu_alu #(.HILO_RESET(32'h00000000)) dut (
    .clk      (clk),
    .reset    (reset),
    .control  (control),
    .a        (a),
    .b        (b),
    .sa       (sa),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .r        (r),
    .zero     (zero),
    .hi       (hi),
`ifdef MIPS_CPU_ALU_OVERFLOW_EN
    .lo       (lo),
    .overflow (overflow)
`else
    .lo       (lo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply a combinational operation and let it settle.
  task automatic comb_op(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] s);
    control = c; a = av; b = bv; sa = s;
    #1;
  endtask

  // Drive a HI/LO-writing operation across exactly one rising edge, then idle.
  task automatic edge_op(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                         input logic hw, input logic lw);
    @(negedge clk);
    control = c; a = av; b = bv; hi_write = hw; lo_write = lw;
    @(posedge clk);
    #1;
    control = 4'b1111; hi_write = 1'b0; lo_write = 1'b0;
  endtask

  initial begin
    reset = 1'b0; control = 4'b1111; a = '0; b = '0; sa = '0;
    hi_write = 1'b0; lo_write = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #1;
    check32("reset_hi", hi, 32'h0);
    check32("reset_lo", lo, 32'h0);
    check32("idle_r", r, 32'h0);
    check1("idle_zero", zero, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // ADD/SUB and zero flag.
    comb_op(4'b0010, 32'hFFFFFFFF, 32'h1, 5'd0);
    check32("add_wrap_r", r, 32'h0);
    check1("add_wrap_zero", zero, 1'b1);
    comb_op(4'b0010, 32'h00000010, 32'h00000022, 5'd0);
    check32("add_r", r, 32'h00000032);
    check1("add_zero", zero, 1'b0);
    comb_op(4'b0011, 32'd5, 32'd5, 5'd0);
    check32("sub_eq_r", r, 32'h0);
    check1("sub_eq_zero", zero, 1'b1);
    comb_op(4'b0011, 32'd3, 32'd5, 5'd0);
    check32("sub_neg_r", r, 32'hFFFFFFFE);

    // Logic operations.
    comb_op(4'b0000, 32'hF0F0_1234, 32'hFF00_00FF, 5'd0);
    check32("and_r", r, 32'hF000_0034);
    comb_op(4'b0001, 32'hF0F0_1234, 32'hFF00_00FF, 5'd0);
    check32("or_r", r, 32'hFFF0_12FF);
    comb_op(4'b0100, 32'hF0F0_1234, 32'hFF00_00FF, 5'd0);
    check32("xor_r", r, 32'h0FF0_12CB);
    comb_op(4'b0101, 32'hF0F0_1234, 32'hFF00_00FF, 5'd0);
    check32("nor_r", r, 32'h000F_ED00);

    // Compare.
    comb_op(4'b0110, 32'hFFFFFFFF, 32'h1, 5'd0);
    check32("slt_r", r, 32'h1);
    comb_op(4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0);
    check32("sltu_r", r, 32'h0);
    check1("sltu_zero", zero, 1'b1);

    // Shifts use sa only; a is ignored.
    comb_op(4'b1010, 32'hFFFFFFFF, 32'h80000000, 5'd4);
    check32("sra_r", r, 32'hF8000000);
    comb_op(4'b1001, 32'hFFFFFFFF, 32'h80000000, 5'd4);
    check32("srl_r", r, 32'h08000000);
    comb_op(4'b1000, 32'hFFFFFFFF, 32'h00000001, 5'd31);
    check32("sll_r", r, 32'h80000000);

    // Mult/div codes drive r to zero.
    comb_op(4'b1011, 32'h5, 32'h7, 5'd0);
    check32("mult_code_r", r, 32'h0);
    check1("mult_code_zero", zero, 1'b1);

`ifdef MIPS_CPU_ALU_OVERFLOW_EN
    comb_op(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
    check1("add_ovf", overflow, 1'b1);
    check32("add_ovf_r", r, 32'h80000000);
    comb_op(4'b0011, 32'h80000000, 32'h1, 5'd0);
    check1("sub_ovf", overflow, 1'b1);
    comb_op(4'b0011, 32'h5, 32'h3, 5'd0);
    check1("sub_no_ovf", overflow, 1'b0);
    comb_op(4'b0000, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0);
    check1("and_no_ovf", overflow, 1'b0);
`endif

    // Multiply, single edge each.
    edge_op(4'b1011, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check32("mult_hi", hi, 32'hFFFFFFFF);
    check32("mult_lo", lo, 32'hFFFFFFFA);
    edge_op(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    check32("multu_hi", hi, 32'hFFFFFFFE);
    check32("multu_lo", lo, 32'h00000001);

    // Divide.
    edge_op(4'b1101, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check32("div_hi", hi, 32'hFFFFFFFF);
    check32("div_lo", lo, 32'hFFFFFFFD);
    edge_op(4'b1110, 32'd7, 32'd0, 1'b0, 1'b0);
    check32("divu0_hi", hi, 32'hFFFFFFFF);
    check32("divu0_lo", lo, 32'hFFFFFFFD);
    edge_op(4'b1110, 32'd23, 32'd5, 1'b0, 1'b0);
    check32("divu_hi", hi, 32'd3);
    check32("divu_lo", lo, 32'd4);
    edge_op(4'b1101, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check32("div_ovf_hi", hi, 32'h0);
    check32("div_ovf_lo", lo, 32'h80000000);
    edge_op(4'b1101, 32'd7, 32'd0, 1'b0, 1'b0);
    check32("div0_hi", hi, 32'h0);
    check32("div0_lo", lo, 32'h80000000);

    // MTHI/MTLO priority over a simultaneous multiply.
    edge_op(4'b1011, 32'd2, 32'd3, 1'b1, 1'b0);
    check32("mthi_pri_hi", hi, 32'h00000002);
    check32("mthi_pri_lo", lo, 32'h00000006);
    edge_op(4'b1100, 32'h12345678, 32'd2, 1'b0, 1'b1);
    check32("mtlo_pri_hi", hi, 32'h00000000);
    check32("mtlo_pri_lo", lo, 32'h12345678);
    edge_op(4'b1111, 32'hCAFEBABE, 32'd0, 1'b1, 1'b1);
    check32("mt_both_hi", hi, 32'hCAFEBABE);
    check32("mt_both_lo", lo, 32'hCAFEBABE);

    // Holding a multiply code over two edges gives the same result.
    @(negedge clk);
    control = 4'b1011; a = 32'd7; b = 32'hFFFFFFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check32("mult_hold_hi", hi, 32'hFFFFFFFF);
    check32("mult_hold_lo", lo, 32'hFFFFFFF9);

    // Reset mid-operation clears at once and discards the pending write.
    @(negedge clk);
    control = 4'b1100; a = 32'h00010000; b = 32'h00010000;
    #1 reset = 1'b1;
    #1;
    check32("rst_mid_hi", hi, 32'h0);
    check32("rst_mid_lo", lo, 32'h0);
    check32("rst_r_follows", r, 32'h0);
    control = 4'b0001;
    #1;
    check32("rst_r_or", r, 32'h00010000);
    @(posedge clk);
    #1;
    check32("rst_hold_lo", lo, 32'h0);
    reset = 1'b0;
    control = 4'b1111;
    @(posedge clk);
    #1;
    check32("post_rst_hi", hi, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
